lsu_engine: RTL
===============

# lsu_engine

Load/store unit that accepts memory requests from the scheduled stage and runs them on the 8-bit external memory bus. Word accesses are split into two little-endian byte beats. The unit holds `lsu_wait` high to freeze the scheduled stage until the access completes. Load results return with the request tag on a one-cycle valid pulse.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `a_rst`  in  1  reset, asynchronous, active-low
- `rq_start`  in  1  request present; held stable by the requester while `lsu_wait`=1
- `rq_cmd`  in  1  1=store, 0=load
- `rq_width`  in  1  1=16-bit word, 0=8-bit byte
- `rq_tag`  in  1  destination tag, returned with load data
- `rq_addr`  in  16  byte address from the AGU
- `rq_wdata`  in  16  store data; byte stores use [7:0]
- `lsu_wait`  out  1  stall to the scheduled stage
- `mem_addr`  out  16  bus address
- `mem_wdata`  out  8  bus write byte
- `mem_re`  out  1  bus read strobe
- `mem_we`  out  1  bus write strobe
- `mem_rdata`  in  8  bus read byte, sampled when `mem_ready`=1
- `mem_ready`  in  1  current beat completes this cycle
- `ld_valid`  out  1  one-cycle load-result pulse
- `ld_data`  out  16  load result
- `ld_tag`  out  1  tag of `ld_data`

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE:
  - If `rq_start`=1: latch cmd, width, tag, addr and wdata into internal registers, then go to LO.
  - No bus strobes are driven in IDLE.
- LO (first beat):
  - `mem_addr` = latched addr.
  - Load: `mem_re`=1. Store: `mem_we`=1 and `mem_wdata` = wdata[7:0].
  - Hold all bus outputs stable until `mem_ready`=1.
  - On `mem_ready`=1: a load captures `mem_rdata` into the low byte. A byte access then goes to DONE; a word access goes to HI.
- HI (second beat):
  - `mem_addr` = latched addr + 1, wrapping 0xFFFF→0x0000.
  - Store drives `mem_wdata` = wdata[15:8].
  - On `mem_ready`=1: a load captures the high byte, then go to DONE.
- DONE:
  - No strobes, `lsu_wait`=0.
  - For loads, `ld_valid`=1 for this cycle only. For stores, `ld_valid` stays 0.
  - `rq_start` is ignored, because the requester still presents the finished request this cycle. Next state is always IDLE.
- `lsu_wait` = (IDLE & `rq_start`) | LO | HI. It is combinational from state and `rq_start`.
- `ld_data`:
  - Byte load: zero-extended, {8'h00, byte}.
  - Word load: {high byte, low byte}.
  - Holds its value until the next load reaches DONE. Stores do not change it.
- `ld_tag` is the latched tag, updated when a load reaches DONE.
- Simultaneous events:
  - `mem_ready` high while in IDLE or DONE is ignored.
  - `rq_start` is sampled only in IDLE.
- Reset (asserted at any time, including mid-beat):
  - State → IDLE.
  - All outputs 0: `lsu_wait`, `mem_re`, `mem_we`, `mem_addr`, `mem_wdata`, `ld_valid`, `ld_data`, `ld_tag`.
  - The aborted access is discarded; nothing is replayed.

## Timing
- Byte access, zero wait states: 3 cycles (IDLE-accept, LO, DONE). `lsu_wait` is high for 2 cycles.
- Word access, zero wait states: 4 cycles. `lsu_wait` is high for 3 cycles.
- Each bus wait cycle (`mem_ready`=0) adds one cycle to the beat and one cycle of `lsu_wait`.
- `ld_valid` rises in the first cycle `lsu_wait` is 0 after acceptance. Data and tag are valid in that cycle.
- Back-to-back requests: a new request is accepted in the cycle after DONE. Maximum issue rate is one byte access per 3 cycles.
- Bus outputs are registered or decoded from registered state only. They do not depend on `rq_*` in the same cycle.

## Structure
- Shared package `lsu_pkg` holds:
  - state encoding `lsu_state_t` (IDLE, LO, HI, DONE);
  - constants `LSU_CMD_LOAD`=0 and `LSU_CMD_STORE`=1;
  - constants `LSU_WIDTH_BYTE`=0 and `LSU_WIDTH_WORD`=1.
- The scheduled stage imports the same package for its request encoding.
- Single module; no sub-module is warranted. The beat mux and address increment are inline logic.

## Test plan
- Byte load from 0x1234, `mem_rdata`=0xAB, `mem_ready` tied 1:
  - `mem_re` high 1 cycle at addr 0x1234;
  - `lsu_wait` high 2 cycles;
  - `ld_valid` pulse with `ld_data`=0x00AB and `ld_tag` equal to `rq_tag`.
- Word store of 0xBEEF to 0x2000:
  - `mem_we` beats are 0x2000/0xEF then 0x2001/0xBE;
  - `ld_valid` stays 0;
  - `lsu_wait` high 3 cycles.
- Word load at 0xFFFF, bytes 0x34 then 0x12, with 2 wait cycles on the first beat:
  - second beat addr = 0x0000;
  - `ld_data`=0x1234;
  - `lsu_wait` high 5 cycles.
- Two back-to-back byte loads with `rq_start` held high through DONE:
  - exactly two accesses, not three;
  - the second is accepted the cycle after the first DONE.
- `a_rst` pulsed low during the HI beat of a word load:
  - all outputs 0 immediately;
  - no `ld_valid`;
  - the next request after reset completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store encodings and LSU state type.
// Imported by the LSU and by the scheduled stage that issues requests.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } lsu_state_t;

  localparam logic LSU_CMD_LOAD   = 1'b0;
  localparam logic LSU_CMD_STORE  = 1'b1;
  localparam logic LSU_WIDTH_BYTE = 1'b0;
  localparam logic LSU_WIDTH_WORD = 1'b1;

  typedef struct packed {
    logic        cmd;
    logic        width;
    logic        tag;
    logic [15:0] addr;
    logic [15:0] wdata;
  } lsu_req_t;

  // Second-beat address; wraps 0xFFFF -> 0x0000.
  function automatic logic [15:0] hi_addr(
    input logic [15:0] a
  );
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/lsu_engine.sv
// Load/store unit: runs byte/word requests as 8-bit bus beats.
// Ports: clk, a_rst, rq_* request, lsu_wait stall, mem_* bus, ld_* result.
module lsu_engine
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        a_rst,
  input  logic        rq_start,
  input  logic        rq_cmd,
  input  logic        rq_width,
  input  logic        rq_tag,
  input  logic [15:0] rq_addr,
  input  logic [15:0] rq_wdata,
  output logic        lsu_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        ld_valid,
  output logic [15:0] ld_data,
  output logic        ld_tag
);

  lsu_state_t state;
  lsu_state_t state_nx;
  lsu_req_t   req;
  logic [7:0] lo_byte;
  logic       is_ld;
  logic       is_st;

  assign is_ld = (req.cmd == LSU_CMD_LOAD);
  assign is_st = (req.cmd == LSU_CMD_STORE);

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Bus outputs decode from registered state/request only.
  always_comb begin
    state_nx  = state;
    lsu_wait  = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    ld_valid  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Gated by reset so the stall drops while reset is held.
        if (rq_start && a_rst) begin
          lsu_wait = 1'b1;
          state_nx = ST_LO;
        end
      end
      ST_LO: begin
        lsu_wait = 1'b1;
        mem_addr = req.addr;
        mem_re   = is_ld;
        mem_we   = is_st;
        if (is_st) begin
          mem_wdata = req.wdata[7:0];
        end
        if (mem_ready) begin
          if (req.width == LSU_WIDTH_WORD) begin
            state_nx = ST_HI;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_HI: begin
        lsu_wait = 1'b1;
        mem_addr = hi_addr(req.addr);
        mem_re   = is_ld;
        mem_we   = is_st;
        if (is_st) begin
          mem_wdata = req.wdata[15:8];
        end
        if (mem_ready) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        // rq_start still shows the finished request here.
        ld_valid = is_ld;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      req     <= '0;
      lo_byte <= 8'h00;
      ld_data <= 16'h0000;
      ld_tag  <= 1'b0;
    end else begin
      if (state == ST_IDLE && rq_start) begin
        req.cmd   <= rq_cmd;
        req.width <= rq_width;
        req.tag   <= rq_tag;
        req.addr  <= rq_addr;
        req.wdata <= rq_wdata;
      end
      if (state == ST_LO && mem_ready && is_ld) begin
        if (req.width == LSU_WIDTH_WORD) begin
          lo_byte <= mem_rdata;
        end else begin
          ld_data <= {8'h00, mem_rdata};
          ld_tag  <= req.tag;
        end
      end
      if (state == ST_HI && mem_ready && is_ld) begin
        ld_data <= {mem_rdata, lo_byte};
        ld_tag  <= req.tag;
      end
    end
  end

endmodule
